// File: rtl/cpu_pkg.sv
// Types and defaults shared between the CPU and its output-port receiver.
package cpu_pkg;
  localparam int DEFAULT_WIDTH = 16;
  typedef logic [DEFAULT_WIDTH-1:0] word_t;
endpackage

// File: rtl/out_fifo.sv
// Storage, pointers and level for the out-port buffer.
// The caller only asserts push/pop when they are legal (no push into a full, no pop from an empty buffer).
module out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/cpu_out_port_rx.sv
// Receiving end of the CPU output port: buffers outFlag-qualified words for a valid/ready consumer.
// Optional saturating word/drop counters are built when OUT_PORT_STATS_EN is defined.
module cpu_out_port_rx
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8
`ifdef OUT_PORT_STATS_EN
  ,
  parameter int CNTWIDTH = 16
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   outFlag,
  input  logic [WIDTH-1:0]       out,
  output logic                   rdValid,
  output logic [WIDTH-1:0]       rdData,
  input  logic                   rdReady,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clearOverflow
`ifdef OUT_PORT_STATS_EN
  ,
  output logic [CNTWIDTH-1:0]    wordCount,
  output logic [CNTWIDTH-1:0]    dropCount
`endif
);
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic [WIDTH-1:0] head;

  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign pop     = !empty && rdReady;
  assign push_ok = outFlag && (!full || pop);
  assign drop    = outFlag && full && !pop;

  out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .wdata (out),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign rdValid = !empty;
  assign rdData  = empty ? '0 : head;

  // Set beats clear so a drop is never lost to a concurrent acknowledge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)             overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
    else if (clearOverflow) overflow <= 1'b0;
  end

`ifdef OUT_PORT_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wordCount <= '0;
      dropCount <= '0;
    end else begin
      if (push_ok && (wordCount != '1)) wordCount <= wordCount + CNTWIDTH'(1);
      if (drop && (dropCount != '1))    dropCount <= dropCount + CNTWIDTH'(1);
    end
  end
`endif
endmodule

// File: tb/tb_cpu_out_port_rx.sv
// Bench for cpu_out_port_rx: directed scenarios followed by random traffic, checked against a queue model.
module tb_cpu_out_port_rx;
  import cpu_pkg::*;

  localparam int DEPTH  = 8;
  localparam int CNTMAX = 65535;

  logic        clock;
  logic        reset;
  logic        outFlag;
  word_t       out;
  logic        rdValid;
  word_t       rdData;
  logic        rdReady;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;
  logic        clearOverflow;
`ifdef OUT_PORT_STATS_EN
  logic [15:0] wordCount;
  logic [15:0] dropCount;
`endif

  cpu_out_port_rx #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .outFlag       (outFlag),
    .out           (out),
    .rdValid       (rdValid),
    .rdData        (rdData),
    .rdReady       (rdReady),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .clearOverflow (clearOverflow)
`ifdef OUT_PORT_STATS_EN
    ,
    .wordCount     (wordCount),
    .dropCount     (dropCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: a queue of buffered words plus flag and counters.
  word_t q[$];
  bit    m_ovf;
  int    m_wc;
  int    m_dc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_wc  = 0;
    m_dc  = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rdValid"}, rdValid, q.size() != 0);
    check({tag, ".rdData"}, rdData, (q.size() != 0) ? q[0] : 16'h0);
    check({tag, ".level"}, level, q.size());
    check({tag, ".full"}, full, q.size() == DEPTH);
    check({tag, ".empty"}, empty, q.size() == 0);
    check({tag, ".overflow"}, overflow, m_ovf);
`ifdef OUT_PORT_STATS_EN
    check({tag, ".wordCount"}, wordCount, m_wc);
    check({tag, ".dropCount"}, dropCount, m_dc);
`endif
  endtask

  // Called just after a falling edge: drive inputs, advance the model, check after the next edge.
  task automatic step(input bit flag, input word_t data, input bit rdy, input bit clr, input string tag);
    bit did_pop;
    bit dropped;
    outFlag       = flag;
    out           = flag ? data : 'x;
    rdReady       = rdy;
    clearOverflow = clr;
    did_pop = rdy && (q.size() != 0);
    dropped = 0;
    if (did_pop) void'(q.pop_front());
    if (flag) begin
      if (q.size() < DEPTH) begin
        q.push_back(data);
        if (m_wc < CNTMAX) m_wc++;
      end else begin
        dropped = 1;
        if (m_dc < CNTMAX) m_dc++;
      end
    end
    if (dropped)  m_ovf = 1;
    else if (clr) m_ovf = 0;
    @(posedge clock);
    @(negedge clock);
    check_state(tag);
  endtask

  initial begin
    int rdy_pct;
    reset = 1'b0; outFlag = 1'b0; out = '0; rdReady = 1'b0; clearOverflow = 1'b0;
    model_reset();
    @(negedge clock);
    check_state("reset");
    reset = 1'b1;
    repeat (5) step(0, '0, 0, 0, "idle");

    step(1, 16'h00A5, 0, 0, "single_push");
    check("single_data", rdData, 16'h00A5);
    check("single_level", level, 1);
    repeat (3) step(0, '0, 0, 0, "single_hold");
    step(0, '0, 1, 0, "single_pop");
    check("single_empty", empty, 1);

    for (int i = 1; i <= 9; i++) step(1, word_t'(i), 0, 0, "fill");
    check("fill_full", full, 1);
    check("fill_overflow", overflow, 1);
    step(0, '0, 0, 1, "fill_clear");

    for (int i = 0; i < 8; i++) step(1, word_t'(16'h10 + i), 1, 0, "full_pushpop");
    check("pushpop_level", level, 8);
    check("pushpop_overflow", overflow, 0);
    check("pushpop_head", rdData, 16'h0010);
    repeat (8) step(0, '0, 1, 0, "drain");
    check("drain_empty", empty, 1);

    for (int i = 0; i < 8; i++) step(1, word_t'(16'h20 + i), 0, 0, "refill");
    step(1, 16'h00DD, 0, 1, "drop_and_clear");
    check("prio_set_wins", overflow, 1);
    step(0, '0, 0, 1, "clear_only");
    check("prio_cleared", overflow, 0);
    repeat (3) step(0, '0, 1, 0, "partial_drain");
    check("five_buffered", level, 5);

    #2 reset = 1'b0;
    #1;
    check("async_empty", empty, 1);
    check("async_rdData", rdData, 0);
    check("async_rdValid", rdValid, 0);
    check("async_level", level, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    check_state("post_reset");
    step(1, 16'hBEEF, 0, 0, "beef_push");
    check("beef_first", rdData, 16'hBEEF);

    for (int i = 0; i < 600; i++) begin
      rdy_pct = ((i / 50) % 2 == 0) ? 20 : 85;
      step($urandom_range(0, 99) < 60, word_t'($urandom), $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 99) < 5, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
